// File: rtl/iic_pkg.sv
// Shared types and constants for the MPU-6050-style I2C target.
package iic_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } iic_tgt_state_t;

  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] REG_WHO_AM_I     = 8'h75;
  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;

  // Power-on content of the register file: device starts asleep, WHO_AM_I is fixed.
  function automatic logic [7:0] reg_reset_val(input logic [7:0] idx, input logic [7:0] whoami);
    logic [7:0] v;
    v = 8'h00;
    if (idx == REG_PWR_MGMT_1) v = 8'h40;
    else if (idx == REG_WHO_AM_I) v = whoami;
    return v;
  endfunction

endpackage

// File: rtl/iic_sync_edge.sv
// Two-flop synchronizer for SCL/SDA with a history flop, producing
// single-cycle SCL edge and START/STOP condition strobes.
module iic_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [0] first sync stage, [1] synchronized level, [2] previous synchronized level.
  // Reset to the idle-bus level so reset release never looks like an event.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign start_o    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_o     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/iic_target.sv
// I2C target emulating the MPU-6050 register interface: pointer write,
// register writes and auto-incrementing burst reads from a local register file.
module iic_target
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h68,
  parameter int         REG_DEPTH  = 128,
  parameter logic [7:0] WHOAMI_VAL = 8'h68
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           scl_i,
  input  logic           sda_i,
  output logic           sda_oe,
  output logic           busy,
  output logic           reg_wr_valid,
  output logic [7:0]     reg_wr_addr,
  output logic [7:0]     reg_wr_data,
  input  logic           loc_we,
  input  logic [7:0]     loc_addr,
  input  logic [7:0]     loc_wdata,
  output iic_tgt_state_t dbg_state_o
);

  localparam int PW = $clog2(REG_DEPTH);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  iic_sync_edge u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  iic_tgt_state_t state_q;
  logic [3:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic [PW-1:0]  ptr_q;
  logic           sda_oe_q, busy_q, wr_valid_q;
  logic [7:0]     wr_addr_q, wr_data_q;
  logic [7:0]     regs_q [REG_DEPTH];

  logic [7:0] rx_byte, rd_byte;
  logic       i2c_we;
  logic       unused_loc_hi;

  assign rx_byte       = {shift_q[6:0], sda_s};
  assign rd_byte       = regs_q[ptr_q];
  assign i2c_we        = (state_q == S_WDATA) && scl_rise && (bit_cnt_q == 4'd7)
                         && !start_det && !stop_det;
  assign unused_loc_hi = ^loc_addr;

  // reg_wr_valid is a one-cycle strobe with no back-pressure: reg_wr_addr and
  // reg_wr_data are meaningful only while it is high and hold their value after.
  assign sda_oe       = sda_oe_q;
  assign busy         = busy_q;
  assign reg_wr_valid = wr_valid_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  assign dbg_state_o  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (start_det) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (stop_det) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                if (state_q == S_ADDR) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_q <= S_ADDR_ACK;
                    busy_q  <= 1'b1;
                  end else begin
                    state_q <= S_IGNORE;
                  end
                end else if (state_q == S_PTR) begin
                  ptr_q   <= rx_byte[PW-1:0];
                  state_q <= S_PTR_ACK;
                end else begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= 8'(ptr_q);
                  wr_data_q  <= rx_byte;
                  ptr_q      <= ptr_q + 1'b1;
                  state_q    <= S_WDATA_ACK;
                end
              end
            end
          end
          // bit_cnt 0: waiting for the 8th fall to pull SDA; 1: waiting for the 9th fall.
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd0) begin
                sda_oe_q  <= 1'b1;
                bit_cnt_q <= 4'd1;
              end else begin
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                if (state_q == S_ADDR_ACK && shift_q[0]) begin
                  state_q  <= S_RDATA;
                  shift_q  <= rd_byte;
                  sda_oe_q <= ~rd_byte[7];
                end else if (state_q == S_ADDR_ACK) begin
                  state_q <= S_PTR;
                end else begin
                  state_q <= S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                state_q   <= S_RDATA_ACK;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              ptr_q <= ptr_q + 1'b1;
              if (sda_s) state_q <= S_IGNORE;
              else       bit_cnt_q <= 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd1) begin
              bit_cnt_q <= '0;
              state_q   <= S_RDATA;
              shift_q   <= rd_byte;
              sda_oe_q  <= ~rd_byte[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The I2C write is applied last so it wins over a same-cycle local write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= reg_reset_val(8'(i), WHOAMI_VAL);
    end else begin
      if (loc_we) regs_q[loc_addr[PW-1:0]] <= loc_wdata;
      if (i2c_we) regs_q[ptr_q] <= rx_byte;
    end
  end

endmodule
